// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] sel2onehot(input logic [SEL_W-1:0] s);
    return N_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_sub.sv
// Building blocks for mux8_rr_arbiter: rotating first-one picker and a 1-bit 8:1 mux tree.
module rr_pick8 import mux8_rr_arbiter_pkg::*; (
  input  logic [N_REQ-1:0] vec,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so bit 0 is the ptr position, find the lowest set bit, then rotate back.
  always_comb begin
    rot = N_REQ'({vec, vec} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = ptr + off;
    any = |vec;
  end

endmodule

module mux8to1 (
  input  logic [7:0] d_i,
  input  logic [2:0] s_i,
  output logic       y_o
);

  logic [3:0] l0;
  logic [1:0] l1;

  always_comb begin
    for (int k = 0; k < 4; k++) l0[k] = s_i[0] ? d_i[2*k+1] : d_i[2*k];
    for (int k = 0; k < 2; k++) l1[k] = s_i[1] ? l0[2*k+1] : l0[2*k];
    y_o = s_i[2] ? l1[1] : l1[0];
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one DATA_W-wide 8:1 mux path between 8 requesters.
// Define MUXARB_BURST_EN to hold a grant until the requester's last beat is accepted.
module mux8_rr_arbiter import mux8_rr_arbiter_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  input  logic [N_REQ-1:0]        in_last,
  output logic [N_REQ-1:0]        ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [N_REQ-1:0] pickVec;
  logic [SEL_W-1:0] pickPtr;
  logic [SEL_W-1:0] pickIdx;
  logic             pickAny;
  logic             accept;
  logic             holdBurst;
  logic             lastSel;

  assign accept = (state_q == ST_BUSY) && out_ready;

`ifdef MUXARB_BURST_EN
  assign lastSel   = in_last[sel_q];
  assign holdBurst = !lastSel;
`else
  logic unusedLast;
  assign unusedLast = ^in_last;
  assign lastSel    = 1'b1;
  assign holdBurst  = 1'b0;
`endif

  // While busy, the picker re-arbitrates as if the current winner were already served.
  assign pickVec = (state_q == ST_BUSY) ? (req & ~sel2onehot(sel_q)) : req;
  assign pickPtr = (state_q == ST_BUSY) ? sel_q + 1'b1 : ptr_q;

  rr_pick8 uPick (
    .vec (pickVec),
    .ptr (pickPtr),
    .any (pickAny),
    .idx (pickIdx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          state_d = ST_BUSY;
          sel_d   = pickIdx;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          if (!holdBurst) begin
            ptr_d = pickPtr;
            if (pickAny) sel_d = pickIdx;
            else         state_d = ST_IDLE;
          end
        end else if (!req[sel_q]) begin
          // Requester withdrew before being served: drop the grant.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_BUSY);
    out_sel   = sel_q;
    out_last  = out_valid & lastSel;
    ack       = (accept && rst_n) ? sel2onehot(sel_q) : '0;
  end

  for (genvar b = 0; b < DATA_W; b++) begin : gBit
    logic [N_REQ-1:0] col;
    for (genvar i = 0; i < N_REQ; i++) begin : gCol
      assign col[i] = in_data[i*DATA_W + b];
    end
    mux8to1 uMux (
      .d_i (col),
      .s_i (out_sel),
      .y_o (out_data[b])
    );
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mux8_rr_arbiter;

  localparam int DW = 8;
`ifdef MUXARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic [7:0]    reqV;
  logic [7:0]    lastV;
  logic [8*DW-1:0] dataV;
  logic          readyV;
  logic [7:0]    ackO;
  logic          validO;
  logic          lastO;
  logic [DW-1:0] dataO;
  logic [2:0]    selO;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req       (reqV),
    .in_data   (dataV),
    .in_last   (lastV),
    .ack       (ackO),
    .out_valid (validO),
    .out_ready (readyV),
    .out_data  (dataO),
    .out_sel   (selO),
    .out_last  (lastO)
  );

  typedef struct {
    logic          valid;
    logic          selKnown;
    int            sel;
    logic [7:0]    ack;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: grant owner, rotating start position, and whether out_sel is defined.
  logic mBusy;
  int   mSel;
  int   mPtr;
  logic mSelKnown;

  logic [8*DW-1:0] dd;
  logic [7:0]      dirLast;
  int              pend[8];

  function automatic int pickFrom(input logic [7:0] cand, input int start);
    for (int k = 0; k < 8; k++) begin
      if (cand[(start + k) % 8]) return (start + k) % 8;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic modelStep(output logic [7:0] ackExp);
    exp_t       e;
    logic [7:0] cand;
    ackExp     = (mBusy && readyV && rstN) ? 8'(1 << mSel) : 8'h00;
    e.valid    = mBusy;
    e.selKnown = mBusy || mSelKnown;
    e.sel      = mSel;
    e.ack      = ackExp;
    e.last     = BURST ? (mBusy && lastV[mSel]) : mBusy;
    e.data     = dataV[mSel*DW +: DW];
    expQ.push_back(e);
    if (!rstN) begin
      mBusy = 1'b0; mSel = 0; mPtr = 0; mSelKnown = 1'b1;
    end else if (!mBusy) begin
      if (reqV != 8'h00) begin
        mBusy = 1'b1;
        mSel  = pickFrom(reqV, mPtr);
      end
    end else if (readyV) begin
      if (!(BURST && !lastV[mSel])) begin
        mPtr = (mSel + 1) % 8;
        cand = reqV & ~(8'(1 << mSel));
        if (cand != 8'h00) mSel = pickFrom(cand, mPtr);
        else begin mBusy = 1'b0; mSelKnown = 1'b0; end
      end
    end else if (!reqV[mSel]) begin
      mBusy = 1'b0; mSelKnown = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic rdy, input logic rs,
                               input logic [7:0] l, input logic [8*DW-1:0] d,
                               output logic [7:0] ackE);
    @(posedge clk);
    #1;
    reqV = r; readyV = rdy; rstN = rs; lastV = l; dataV = d;
    modelStep(ackE);
  endtask

  task automatic dirStep(input logic [7:0] r, input logic rdy, input logic rs);
    logic [7:0] ackE;
    applyStimulus(r, rdy, rs, dirLast, dd, ackE);
  endtask

  // Monitor: every cycle the DUT presents outputs, pop the matching expectation.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("out_valid", int'(validO), int'(e.valid));
      checkOutput("ack", int'(ackO), int'(e.ack));
      checkOutput("out_last", int'(lastO), int'(e.last));
      if (e.valid) begin
        checkOutput("out_sel", int'(selO), e.sel);
        checkOutput("out_data", int'(dataO), int'(e.data));
      end else if (e.selKnown) begin
        checkOutput("out_sel_idle", int'(selO), e.sel);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]      r, l, ackE;
    logic            rdy, rs;
    logic [8*DW-1:0] nd;
    rstN = 1'b0; reqV = 8'h00; readyV = 1'b0; lastV = 8'h00; dataV = '0;
    dirLast = 8'hFF;
    for (int i = 0; i < 8; i++) dd[i*DW +: DW] = DW'($urandom);
    mBusy = 1'b0; mSel = 0; mPtr = 0; mSelKnown = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state and idle with no requests.
    dirStep(8'h00, 1'b0, 1'b0);
    dirStep(8'h00, 1'b0, 1'b0);
    repeat (5) dirStep(8'h00, 1'b0, 1'b1);

    // Single request: one-cycle latency, then pointer lands at 5.
    dd[4*DW +: DW] = 8'hA5;
    dirStep(8'h10, 1'b1, 1'b1);
    dirStep(8'h10, 1'b1, 1'b1);
    repeat (2) dirStep(8'h00, 1'b1, 1'b1);
    dirStep(8'h21, 1'b1, 1'b1);
    dirStep(8'h21, 1'b1, 1'b1);
    dirStep(8'h01, 1'b1, 1'b1);
    dirStep(8'h00, 1'b1, 1'b1);

    // All requesting: full rotation at one beat per cycle.
    dirStep(8'hFF, 1'b1, 1'b0);
    repeat (10) dirStep(8'hFF, 1'b1, 1'b1);
    dirStep(8'h00, 1'b0, 1'b0);

    // Backpressure on grant 2 while requester 6 arrives.
    dirStep(8'h04, 1'b0, 1'b1);
    repeat (4) dirStep(8'h44, 1'b0, 1'b1);
    dirStep(8'h44, 1'b1, 1'b1);
    dirStep(8'h40, 1'b1, 1'b1);
    dirStep(8'h00, 1'b0, 1'b1);

    // Withdrawn request aborts the grant without moving the pointer (still 7).
    dirStep(8'h02, 1'b0, 1'b1);
    dirStep(8'h02, 1'b0, 1'b1);
    dirStep(8'h00, 1'b0, 1'b1);
    dirStep(8'h00, 1'b0, 1'b1);
    dirStep(8'h06, 1'b1, 1'b1);
    dirStep(8'h06, 1'b1, 1'b1);
    dirStep(8'h04, 1'b1, 1'b1);
    dirStep(8'h00, 1'b0, 1'b1);

    // Reset while busy on 3, then 3 wins again from pointer 0.
    dirStep(8'h00, 1'b0, 1'b0);
    dirStep(8'h08, 1'b0, 1'b1);
    dirStep(8'h08, 1'b0, 1'b1);
    dirStep(8'h08, 1'b1, 1'b0);
    dirStep(8'h88, 1'b0, 1'b1);
    dirStep(8'h88, 1'b1, 1'b1);
    dirStep(8'h80, 1'b1, 1'b1);
    dirStep(8'h00, 1'b0, 1'b1);

`ifdef MUXARB_BURST_EN
    dirStep(8'h00, 1'b0, 1'b0);
    dirLast = 8'h00;
    repeat (3) dirStep(8'h03, 1'b1, 1'b1);
    dirLast = 8'h01;
    dirStep(8'h03, 1'b1, 1'b1);
    dirLast = 8'h02;
    dirStep(8'h02, 1'b1, 1'b1);
    dirLast = 8'hFF;
    dirStep(8'h00, 1'b0, 1'b1);
`endif

    // Random traffic: each requester issues packets of 1-3 beats and holds req until acked.
    for (int i = 0; i < 8; i++) pend[i] = 0;
    nd = dd;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 99) < 25) begin
          pend[i] = $urandom_range(1, 3);
          nd[i*DW +: DW] = DW'($urandom);
        end
        r[i] = (pend[i] != 0);
        l[i] = (pend[i] == 1);
      end
      rdy = ($urandom_range(0, 99) < 70);
      rs  = ($urandom_range(0, 99) >= 1);
      applyStimulus(r, rdy, rs, l, nd, ackE);
      for (int i = 0; i < 8; i++) begin
        if (ackE[i]) begin
          pend[i]--;
          nd[i*DW +: DW] = DW'($urandom);
        end
      end
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drain", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
